// File: rtl/fp_align_unit.sv
// fp_align_unit: operand pre-processing for the single-precision add/sub path.
// Picks the larger-magnitude operand, then right-shifts the smaller mantissa
// one bit per cycle (or flushes it in one step for large exponent gaps),
// collecting a sticky bit. One operation is in flight at a time.
module fp_align_unit #(
  parameter int EXP_W     = 8,
  parameter int MANT_W    = 24,
  parameter int FLUSH_LIM = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       a_in,
  input  logic [31:0]       b_in,
  input  logic              op_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              s,
  output logic              sign_a,
  output logic              sign_b,
  output logic              op,
  output logic [EXP_W-1:0]  exp_out,
  output logic [MANT_W-1:0] mant_big,
  output logic [MANT_W-1:0] mant_small,
  output logic              sticky
);

  localparam int FRAC_W = MANT_W - 1;
  localparam int MAG_W  = EXP_W + FRAC_W;
  localparam logic [EXP_W-1:0]  EXP_ZERO  = {EXP_W{1'b0}};
  localparam logic [EXP_W-1:0]  EXP_ONE   = EXP_W'(1);
  localparam logic [EXP_W-1:0]  FLUSH_V   = EXP_W'(FLUSH_LIM);
  localparam logic [MANT_W-1:0] MANT_ZERO = {MANT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Denormals (exponent 0) behave as exponent 1 when measuring the gap.
  function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
    return (e == EXP_ZERO) ? EXP_ONE : e;
  endfunction

  // Mantissa with the hidden bit restored (0 for denormals).
  function automatic logic [MANT_W-1:0] full_mant(input logic [EXP_W-1:0] e,
                                                  input logic [FRAC_W-1:0] f);
    return {(e != EXP_ZERO), f};
  endfunction

  state_t              state_q, state_d;
  logic [EXP_W-1:0]    cnt_q, cnt_d;
  logic                s_q, s_d;
  logic                sign_a_q, sign_a_d;
  logic                sign_b_q, sign_b_d;
  logic                op_q, op_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic [MANT_W-1:0]   mant_big_q, mant_big_d;
  logic [MANT_W-1:0]   mant_small_q, mant_small_d;
  logic                sticky_q, sticky_d;
  logic                out_valid_q, out_valid_d;

  logic [EXP_W-1:0]    exp_a_s, exp_b_s, eff_big_s, eff_small_s, diff_s;
  logic [MANT_W-1:0]   mant_a_s, mant_b_s, big_s, small_s;
  logic                swap_s;

  // Decode operands, choose larger magnitude and compute the exponent gap.
  always_comb begin
    exp_a_s  = a_in[FRAC_W +: EXP_W];
    exp_b_s  = b_in[FRAC_W +: EXP_W];
    mant_a_s = full_mant(exp_a_s, a_in[FRAC_W-1:0]);
    mant_b_s = full_mant(exp_b_s, b_in[FRAC_W-1:0]);
    swap_s   = (a_in[MAG_W-1:0] < b_in[MAG_W-1:0]);
    if (swap_s) begin
      big_s       = mant_b_s;
      small_s     = mant_a_s;
      eff_big_s   = eff_exp(exp_b_s);
      eff_small_s = eff_exp(exp_a_s);
    end else begin
      big_s       = mant_a_s;
      small_s     = mant_b_s;
      eff_big_s   = eff_exp(exp_a_s);
      eff_small_s = eff_exp(exp_b_s);
    end
    diff_s = eff_big_s - eff_small_s;
  end

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    s_d          = s_q;
    sign_a_d     = sign_a_q;
    sign_b_d     = sign_b_q;
    op_d         = op_q;
    exp_d        = exp_q;
    mant_big_d   = mant_big_q;
    mant_small_d = mant_small_q;
    sticky_d     = sticky_q;
    out_valid_d  = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        out_valid_d = 1'b0;
        if (in_valid) begin
          s_d          = swap_s;
          sign_a_d     = a_in[MAG_W];
          sign_b_d     = b_in[MAG_W];
          op_d         = op_in;
          exp_d        = swap_s ? exp_b_s : exp_a_s;
          mant_big_d   = big_s;
          mant_small_d = small_s;
          sticky_d     = 1'b0;
          cnt_d        = diff_s;
          if (diff_s == EXP_ZERO) begin
            state_d = ST_DONE;
          end else if (diff_s >= FLUSH_V) begin
            // Every bit would fall off the end: collapse it into sticky now.
            sticky_d     = |small_s;
            mant_small_d = MANT_ZERO;
            state_d      = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        mant_small_d = mant_small_q >> 1;
        sticky_d     = sticky_q | mant_small_q[0];
        cnt_d        = cnt_q - EXP_ONE;
        if (cnt_q == EXP_ONE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        // Data is already settled; out_valid follows one edge later.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset to all-zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= EXP_ZERO;
      s_q          <= 1'b0;
      sign_a_q     <= 1'b0;
      sign_b_q     <= 1'b0;
      op_q         <= 1'b0;
      exp_q        <= EXP_ZERO;
      mant_big_q   <= MANT_ZERO;
      mant_small_q <= MANT_ZERO;
      sticky_q     <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      s_q          <= s_d;
      sign_a_q     <= sign_a_d;
      sign_b_q     <= sign_b_d;
      op_q         <= op_d;
      exp_q        <= exp_d;
      mant_big_q   <= mant_big_d;
      mant_small_q <= mant_small_d;
      sticky_q     <= sticky_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE) && !rst;
  assign out_valid  = out_valid_q;
  assign s          = s_q;
  assign sign_a     = sign_a_q;
  assign sign_b     = sign_b_q;
  assign op         = op_q;
  assign exp_out    = exp_q;
  assign mant_big   = mant_big_q;
  assign mant_small = mant_small_q;
  assign sticky     = sticky_q;

endmodule

// File: tb/tb_fp_align_unit.sv
// Scoreboard bench for fp_align_unit: the driver pushes model results when a
// pair is accepted; a negedge monitor compares whenever out_valid is high.
module tb_fp_align_unit;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, op_in, out_valid, out_ready;
  logic [31:0] a_in, b_in;
  logic        s, sign_a, sign_b, op, sticky;
  logic [7:0]  exp_out;
  logic [23:0] mant_big, mant_small;

  fp_align_unit #(.EXP_W(8), .MANT_W(24), .FLUSH_LIM(26)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .op_in(op_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .sign_a(sign_a), .sign_b(sign_b), .op(op), .exp_out(exp_out),
    .mant_big(mant_big), .mant_small(mant_small), .sticky(sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s, sa, sb, op, st;
    logic [7:0]  ex;
    logic [23:0] mb, ms;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   nchecks = 0;
  int   nfail   = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;
  logic prev_ov = 1'b0;
  logic rnd_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nchecks++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: plain arithmetic on the IEEE fields.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic o);
    exp_t   e;
    longint ea, eb, fa, fb, ma, mb, ebig, esml, msml, d;
    ea = longint'(a[30:23]);  eb = longint'(b[30:23]);
    fa = longint'(a[22:0]);   fb = longint'(b[22:0]);
    ma = (ea != 0 ? 64'd8388608 : 64'd0) + fa;
    mb = (eb != 0 ? 64'd8388608 : 64'd0) + fb;
    e.s  = (ea * 8388608 + fa) < (eb * 8388608 + fb);
    e.sa = a[31];
    e.sb = b[31];
    e.op = o;
    if (e.s) begin
      e.ex = b[30:23]; e.mb = mb[23:0]; msml = ma;
      ebig = (eb == 0) ? 1 : eb; esml = (ea == 0) ? 1 : ea;
    end else begin
      e.ex = a[30:23]; e.mb = ma[23:0]; msml = mb;
      ebig = (ea == 0) ? 1 : ea; esml = (eb == 0) ? 1 : eb;
    end
    d = ebig - esml;
    if (d >= 26) begin
      e.ms = 24'd0; e.st = (msml != 0); e.lat = 1;
    end else begin
      e.ms  = 24'(msml >> d);
      e.st  = ((msml % (64'd1 << d)) != 0);
      e.lat = (d == 0) ? 1 : int'(d) + 1;
    end
    return e;
  endfunction

  // Monitor: latency on the rising edge of out_valid, fields every valid cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_cyc = cyc;
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = q[0];
          if (!prev_ov) chk("latency", 32'(cyc - acc_cyc - 1), 32'(e.lat));
          chk("s", 32'(s), 32'(e.s));
          chk("sign_a", 32'(sign_a), 32'(e.sa));
          chk("sign_b", 32'(sign_b), 32'(e.sb));
          chk("op", 32'(op), 32'(e.op));
          chk("exp_out", 32'(exp_out), 32'(e.ex));
          chk("mant_big", 32'(mant_big), 32'(e.mb));
          chk("mant_small", 32'(mant_small), 32'(e.ms));
          chk("sticky", 32'(sticky), 32'(e.st));
          if (out_ready) void'(q.pop_front());
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic o);
    int n = 0;
    a_in = a; b_in = b; op_in = o; in_valid = 1'b1;
    while (!in_ready && n < 300) begin tick(); n++; end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      q.push_back(model(a, b, o));
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin tick(); n++; end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"}, {s, sign_a, sign_b, op, sticky, exp_out, mant_big[18:0]}, 32'd0);
    chk({tag, "_mant_small"}, 32'(mant_small), 32'd0);
    chk({tag, "_mant_big_hi"}, 32'(mant_big[23:19]), 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          e;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_in = 1'b0;
    a_in = 32'd0; b_in = 32'd0;
    repeat (3) tick();
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk_zero_outputs("reset");
    rst = 1'b0;
    tick();
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Directed cases from the plan.
    out_ready = 1'b1;
    send(32'h40400000, 32'h3F800000, 1'b0); drain();
    send(32'h3F800000, 32'h40400000, 1'b1); drain();
    send(32'h3FC00000, 32'hBF800000, 1'b0); drain();
    send(32'h3F800000, 32'h3F800000, 1'b0); drain();
    send(32'h4B800000, 32'h3F800001, 1'b0); drain();
    send(32'h50000000, 32'h3F800000, 1'b1); drain();
    send(32'h00000001, 32'h00800000, 1'b0); drain();

    // Backpressure: hold DONE, offer a competing pair that must be ignored.
    out_ready = 1'b0;
    send(32'h40400000, 32'h3F800000, 1'b0);
    for (int i = 0; i < 40 && !out_valid; i++) tick();
    chk("hold_reached_valid", 32'(out_valid), 32'd1);
    a_in = 32'h12345678; b_in = 32'h7F000000; op_in = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
    send(32'h3F800000, 32'h41200000, 1'b0);
    drain();

    // Reset in the middle of a long shift: nothing must come out.
    send(32'h4B800000, 32'h3F800001, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    q.delete();
    tick();
    rst = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk_zero_outputs("abort");
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end
    send(32'h4B800000, 32'h3F800001, 1'b0); drain();

    // Randomized pairs with exponents clustered so all paths get hit.
    rnd_rdy = 1'b1;
    for (int k = 0; k < 150; k++) begin
      ra = $urandom;
      e  = int'(ra[30:23]) + int'($urandom_range(0, 64)) - 32;
      if (e < 0) e = 0;
      if (e > 255) e = 255;
      rb = $urandom;
      rb[30:23] = 8'(e);
      if ($urandom_range(0, 7) == 0) rb[22:0] = 23'd0;
      send(ra, rb, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick();
    end
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
